// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
// Optional performance counters are enabled with the ID_EX_PERF_CNT_EN macro.
package id_ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int ALUW = 5;

  localparam logic [RAW-1:0] ZERO_REG = 5'd0;

  // What the stage register does in a given cycle
  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } stage_act_e;

  // Full contents of the ID/EX register
  typedef struct packed {
    logic            valid;
    logic            wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [ALUW-1:0] alu_op;
    logic [RAW-1:0]  rs1;
    logic [RAW-1:0]  rs2;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  // Turn a stage image into a bubble: control and addresses cleared so
  // forwarding can never match; data fields keep their old values.
  function automatic id_ex_t make_bubble(input id_ex_t cur);
    id_ex_t b;
    b         = cur;
    b.valid   = 1'b0;
    b.wen     = 1'b0;
    b.mem_ren = 1'b0;
    b.mem_wen = 1'b0;
    b.rs1     = ZERO_REG;
    b.rs2     = ZERO_REG;
    b.rd      = ZERO_REG;
    return b;
  endfunction

  // Saturating increment of a 32-bit count
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus of the ID/EX stage: decoded inputs, pipeline
// control, registered EX outputs and the decode stall request.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_op1;
  logic [XLEN-1:0] id_op2;
  logic [XLEN-1:0] id_imm;
  logic [RAW-1:0]  id_rs1;
  logic [RAW-1:0]  id_rs2;
  logic [RAW-1:0]  id_rd;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic            id_wen;
  logic            id_mem_ren;
  logic            id_mem_wen;
  logic [ALUW-1:0] id_alu_op;
  logic            flush;
  logic            ex_stall;

  logic            ex_valid;
  logic            ex_wen;
  logic            ex_mem_ren;
  logic            ex_mem_wen;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_imm;
  logic [ALUW-1:0] ex_alu_op;
  logic [RAW-1:0]  ID_EX_rs1;
  logic [RAW-1:0]  ID_EX_rs2;
  logic [RAW-1:0]  ex_rd;
  logic            id_stall;

  // Surrounding pipeline: drives decode fields and control, observes EX
  modport master (
    output id_valid, id_pc, id_op1, id_op2, id_imm, id_rs1, id_rs2, id_rd,
           id_rs1_used, id_rs2_used, id_wen, id_mem_ren, id_mem_wen,
           id_alu_op, flush, ex_stall,
    input  ex_valid, ex_wen, ex_mem_ren, ex_mem_wen, ex_pc, ex_op1, ex_op2,
           ex_imm, ex_alu_op, ID_EX_rs1, ID_EX_rs2, ex_rd, id_stall
  );

  // The ID/EX stage itself
  modport slave (
    input  id_valid, id_pc, id_op1, id_op2, id_imm, id_rs1, id_rs2, id_rd,
           id_rs1_used, id_rs2_used, id_wen, id_mem_ren, id_mem_wen,
           id_alu_op, flush, ex_stall,
    output ex_valid, ex_wen, ex_mem_ren, ex_mem_wen, ex_pc, ex_op1, ex_op2,
           ex_imm, ex_alu_op, ID_EX_rs1, ID_EX_rs2, ex_rd, id_stall
  );

endinterface

// File: rtl/id_ex_stage_sat_cnt32.sv
// sat_cnt32: 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt32
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_r;

  // Count enabled events, saturating at the top value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 32'd0;
    end else if (inc) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with inline load-use hazard detection.
// Define ID_EX_PERF_CNT_EN to add the bubble_cnt / flush_cnt counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]  bubble_cnt,
  output logic [31:0]  flush_cnt
`endif
);

  id_ex_t     stage_r;
  id_ex_t     stage_nxt_s;
  id_ex_t     capture_s;
  stage_act_e act_s;
  logic       rs1_hit_s;
  logic       rs2_hit_s;
  logic       load_use_s;

  // Load-use detection against the load currently sitting in EX
  always_comb begin
    rs1_hit_s  = bus.id_rs1_used && (bus.id_rs1 == stage_r.rd);
    rs2_hit_s  = bus.id_rs2_used && (bus.id_rs2 == stage_r.rd);
    load_use_s = stage_r.valid && stage_r.mem_ren && (stage_r.rd != ZERO_REG)
                 && bus.id_valid && (rs1_hit_s || rs2_hit_s);
  end

  // Priority: flush > ex_stall > load-use > normal capture
  always_comb begin
    act_s = ACT_LOAD;
    if (bus.flush) begin
      act_s = ACT_BUBBLE;
    end else if (bus.ex_stall) begin
      act_s = ACT_HOLD;
    end else if (load_use_s) begin
      act_s = ACT_BUBBLE;
    end else begin
      act_s = ACT_LOAD;
    end
  end

  // Image of the decode slot as it would be captured
  always_comb begin
    capture_s.valid   = bus.id_valid;
    capture_s.wen     = bus.id_wen;
    capture_s.mem_ren = bus.id_mem_ren;
    capture_s.mem_wen = bus.id_mem_wen;
    capture_s.alu_op  = bus.id_alu_op;
    capture_s.rs1     = bus.id_rs1;
    capture_s.rs2     = bus.id_rs2;
    capture_s.rd      = bus.id_rd;
    capture_s.pc      = bus.id_pc;
    capture_s.op1     = bus.id_op1;
    capture_s.op2     = bus.id_op2;
    capture_s.imm     = bus.id_imm;
  end

  // Next register contents; an empty decode slot loads as a bubble
  always_comb begin
    stage_nxt_s = stage_r;
    case (act_s)
      ACT_HOLD: begin
        stage_nxt_s = stage_r;
      end
      ACT_BUBBLE: begin
        stage_nxt_s = make_bubble(stage_r);
      end
      ACT_LOAD: begin
        if (bus.id_valid) begin
          stage_nxt_s = capture_s;
        end else begin
          stage_nxt_s = make_bubble(stage_r);
        end
      end
      default: begin
        stage_nxt_s = stage_r;
      end
    endcase
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= '0;
    end else begin
      stage_r <= stage_nxt_s;
    end
  end

  assign bus.ex_valid   = stage_r.valid;
  assign bus.ex_wen     = stage_r.wen;
  assign bus.ex_mem_ren = stage_r.mem_ren;
  assign bus.ex_mem_wen = stage_r.mem_wen;
  assign bus.ex_alu_op  = stage_r.alu_op;
  assign bus.ID_EX_rs1  = stage_r.rs1;
  assign bus.ID_EX_rs2  = stage_r.rs2;
  assign bus.ex_rd      = stage_r.rd;
  assign bus.ex_pc      = stage_r.pc;
  assign bus.ex_op1     = stage_r.op1;
  assign bus.ex_op2     = stage_r.op2;
  assign bus.ex_imm     = stage_r.imm;

  // A flush kills the load-use request; EX busy always holds decode
  assign bus.id_stall = bus.ex_stall || (load_use_s && !bus.flush);

`ifdef ID_EX_PERF_CNT_EN
  logic bubble_inc_s;
  logic flush_inc_s;

  // A load-use bubble counts only when it is actually loaded
  always_comb begin
    bubble_inc_s = (act_s == ACT_BUBBLE) && !bus.flush && load_use_s;
    flush_inc_s  = bus.flush;
  end

  sat_cnt32 u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_inc_s),
    .cnt   (bubble_cnt)
  );

  sat_cnt32 u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .cnt   (flush_cnt)
  );
`else
  // Counters are not built; the stage behaves identically without them.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_stage_if bus();

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_pc = 32'd0; bus.id_op1 = 32'd0; bus.id_op2 = 32'd0;
    bus.id_imm = 32'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rd = 5'd0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_wen = 1'b0;
    bus.id_mem_ren = 1'b0; bus.id_mem_wen = 1'b0; bus.id_alu_op = 5'd0;
    bus.flush = 1'b0; bus.ex_stall = 1'b0;
  endtask

  // Present one valid instruction on the decode slot
  task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic r1u,
                       input logic [4:0] rs2, input logic r2u, input logic [4:0] rd,
                       input logic load);
    bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_op1 = pc + 32'd1; bus.id_op2 = pc + 32'd2;
    bus.id_imm = pc + 32'd3; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_rs1_used = r1u; bus.id_rs2_used = r2u; bus.id_wen = 1'b1;
    bus.id_mem_ren = load; bus.id_mem_wen = 1'b0; bus.id_alu_op = 5'd2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"},   {31'd0, bus.ex_valid},   32'd0);
    chk({tag, ".wen"},     {31'd0, bus.ex_wen},     32'd0);
    chk({tag, ".mem_ren"}, {31'd0, bus.ex_mem_ren}, 32'd0);
    chk({tag, ".mem_wen"}, {31'd0, bus.ex_mem_wen}, 32'd0);
    chk({tag, ".pc"},      bus.ex_pc,               32'd0);
    chk({tag, ".op1"},     bus.ex_op1,              32'd0);
    chk({tag, ".op2"},     bus.ex_op2,              32'd0);
    chk({tag, ".imm"},     bus.ex_imm,              32'd0);
    chk({tag, ".alu"},     {27'd0, bus.ex_alu_op},  32'd0);
    chk({tag, ".rs1"},     {27'd0, bus.ID_EX_rs1},  32'd0);
    chk({tag, ".rs2"},     {27'd0, bus.ID_EX_rs2},  32'd0);
    chk({tag, ".rd"},      {27'd0, bus.ex_rd},      32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".bcnt"},    bubble_cnt,              32'd0);
    chk({tag, ".fcnt"},    flush_cnt,               32'd0);
`endif
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] b, input logic [31:0] f);
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".bcnt"}, bubble_cnt, b);
    chk({tag, ".fcnt"}, flush_cnt,  f);
`else
    if (b == f) begin end
`endif
  endtask

  initial begin
    logic [31:0] held_pc;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    #2;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal capture
    instr(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
    #1 chk("cap.stall", {31'd0, bus.id_stall}, 32'd0);
    cyc();
    chk("cap.valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("cap.pc",    bus.ex_pc,  32'h100);
    chk("cap.op1",   bus.ex_op1, 32'h101);
    chk("cap.op2",   bus.ex_op2, 32'h102);
    chk("cap.imm",   bus.ex_imm, 32'h103);
    chk("cap.alu",   {27'd0, bus.ex_alu_op}, 32'd2);
    chk("cap.rs1",   {27'd0, bus.ID_EX_rs1}, 32'd1);
    chk("cap.rs2",   {27'd0, bus.ID_EX_rs2}, 32'd2);
    chk("cap.rd",    {27'd0, bus.ex_rd},     32'd3);
    chk("cap.wen",   {31'd0, bus.ex_wen},    32'd1);

    // Load x5 then dependent rs1=x5: one bubble, then the dependent
    instr(32'h104, 5'd6, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    cyc();
    chk("ld5.mem_ren", {31'd0, bus.ex_mem_ren}, 32'd1);
    chk("ld5.rd",      {27'd0, bus.ex_rd},      32'd5);
    instr(32'h108, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
    #1 chk("lu.stall", {31'd0, bus.id_stall}, 32'd1);
    cyc();
    chk("lu.valid",   {31'd0, bus.ex_valid},   32'd0);
    chk("lu.rd",      {27'd0, bus.ex_rd},      32'd0);
    chk("lu.rs1",     {27'd0, bus.ID_EX_rs1},  32'd0);
    chk("lu.mem_ren", {31'd0, bus.ex_mem_ren}, 32'd0);
    chk_cnt("lu", 32'd1, 32'd0);
    chk("lu.stall2", {31'd0, bus.id_stall}, 32'd0);
    cyc();
    chk("dep.valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("dep.pc",    bus.ex_pc, 32'h108);
    chk("dep.rs1",   {27'd0, bus.ID_EX_rs1}, 32'd5);
    chk("dep.rd",    {27'd0, bus.ex_rd},     32'd8);

    // Load x0 then reader of x0: no stall
    instr(32'h10C, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    cyc();
    instr(32'h110, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0);
    #1 chk("x0.stall", {31'd0, bus.id_stall}, 32'd0);
    cyc();
    chk("x0.pc", bus.ex_pc, 32'h110);
    chk("x0.valid", {31'd0, bus.ex_valid}, 32'd1);

    // Load x7 then rs2=x7 not used: no stall
    instr(32'h114, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    cyc();
    instr(32'h118, 5'd1, 1'b1, 5'd7, 1'b0, 5'd4, 1'b0);
    #1 chk("nu.stall", {31'd0, bus.id_stall}, 32'd0);
    cyc();
    chk("nu.pc", bus.ex_pc, 32'h118);
    chk_cnt("nu", 32'd1, 32'd0);

    // Load x9, dependent (rs2 used) with flush: flush wins, no bubble counted
    instr(32'h11C, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    cyc();
    instr(32'h120, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b0);
    #1 chk("fl.lu_stall", {31'd0, bus.id_stall}, 32'd1);
    bus.flush = 1'b1;
    #1 chk("fl.stall", {31'd0, bus.id_stall}, 32'd0);
    cyc();
    bus.flush = 1'b0;
    chk("fl.valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fl.rd",    {27'd0, bus.ex_rd},    32'd0);
    chk_cnt("fl", 32'd1, 32'd1);

    // Load x10, dependent under ex_stall for 3 cycles
    instr(32'h124, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
    cyc();
    held_pc = bus.ex_pc;
    chk("st.ldpc", held_pc, 32'h124);
    instr(32'h128, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b0);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("st.stall", {31'd0, bus.id_stall}, 32'd1);
      cyc();
      chk("st.pc",  bus.ex_pc, 32'h124);
      chk("st.rd",  {27'd0, bus.ex_rd}, 32'd10);
      chk("st.ren", {31'd0, bus.ex_mem_ren}, 32'd1);
    end
    chk_cnt("st", 32'd1, 32'd1);
    bus.ex_stall = 1'b0;
    #1 chk("st.lu", {31'd0, bus.id_stall}, 32'd1);
    cyc();
    chk("st.bub", {31'd0, bus.ex_valid}, 32'd0);
    chk_cnt("st.bub", 32'd2, 32'd1);
    cyc();
    chk("st.dep", bus.ex_pc, 32'h128);
    chk("st.deprd", {27'd0, bus.ex_rd}, 32'd11);

    // flush together with ex_stall: stage cleared
    bus.flush = 1'b1;
    bus.ex_stall = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.ex_stall = 1'b0;
    chk("fs.valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fs.rd",    {27'd0, bus.ex_rd},    32'd0);
    chk_cnt("fs", 32'd2, 32'd2);

    // id_valid=0 captures a bubble
    instr(32'h12C, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
    bus.id_valid = 1'b0;
    cyc();
    chk("iv.valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("iv.wen",   {31'd0, bus.ex_wen},   32'd0);
    chk("iv.rd",    {27'd0, bus.ex_rd},    32'd0);

`ifdef ID_EX_PERF_CNT_EN
    // Saturation of the bubble counter
    force dut.u_bubble_cnt.cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.u_bubble_cnt.cnt_r;
    for (int k = 0; k < 2; k++) begin
      instr(32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1);
      cyc();
      instr(32'h204, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b0);
      cyc();
      chk("sat.bcnt", bubble_cnt, 32'hFFFF_FFFF);
      cyc();
    end
`endif

    // Asynchronous reset mid-run, away from any clock edge
    instr(32'h300, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1);
    bus.id_mem_wen = 1'b1;
    cyc();
    chk("pre.valid", {31'd0, bus.ex_valid}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid");
    @(negedge clk);
    rst_n = 1'b1;
    instr(32'h400, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0);
    cyc();
    chk("post.pc",    bus.ex_pc, 32'h400);
    chk("post.valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("post.rd",    {27'd0, bus.ex_rd},    32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
